// File: rtl/muldiv_ctrl.sv
// Multi-cycle HI/LO multiply/divide sequencer: 1-bit/cycle shift-add multiplier
// and restoring divider, with pipeline stall, flush annulment and sign fixup.
module muldiv_ctrl #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              annul,
  output logic              busy,
  output logic              stall_req,
  output logic              done,
  output logic              whilo_out,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              div_by_zero
);

  localparam int unsigned CW = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              state_q;
  // MUL: {partial product, remaining multiplier}; DIV: {remainder, quotient}
  logic [2*DATA_W-1:0] acc_q;
  logic [DATA_W-1:0]   opnd_q;
  logic [CW-1:0]       cnt_q;
  logic                neg_res_q, neg_rem_q, dbz_q;
  logic [DATA_W-1:0]   hi_q, lo_q;

  logic                sgn;
  logic [DATA_W-1:0]   mag1, mag2;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_nx;
  logic [DATA_W:0]     div_sh;
  logic [DATA_W+1:0]   div_diff;
  logic [2*DATA_W-1:0] div_nx;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quot_fix, rem_fix;

  always_comb begin
    sgn      = ~op[0];
    mag1     = (sgn && src1[DATA_W-1]) ? -src1 : src1;
    mag2     = (sgn && src2[DATA_W-1]) ? -src2 : src2;
    mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nx   = {mul_sum, acc_q[DATA_W-1:1]};
    // Shifted remainder keeps its carry bit so a full-width divisor still compares correctly
    div_sh   = acc_q[2*DATA_W-1:DATA_W-1];
    div_diff = {1'b0, div_sh} - {2'b00, opnd_q};
    div_nx   = div_diff[DATA_W+1] ? {div_sh[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
                                  : {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    prod_fix = neg_res_q ? -mul_nx : mul_nx;
    quot_fix = neg_res_q ? -div_nx[DATA_W-1:0] : div_nx[DATA_W-1:0];
    rem_fix  = neg_rem_q ? -div_nx[2*DATA_W-1:DATA_W] : div_nx[2*DATA_W-1:DATA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !annul) begin
            if (op[1] && (src2 == '0)) begin
              hi_q    <= src1;
              lo_q    <= '1;
              dbz_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              acc_q     <= {{DATA_W{1'b0}}, (op[1] ? mag1 : mag2)};
              opnd_q    <= op[1] ? mag2 : mag1;
              neg_res_q <= sgn && (src1[DATA_W-1] ^ src2[DATA_W-1]);
              neg_rem_q <= sgn && src1[DATA_W-1];
              cnt_q     <= CW'(DATA_W);
              state_q   <= op[1] ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL: begin
          if (annul) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= mul_nx;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              hi_q    <= prod_fix[2*DATA_W-1:DATA_W];
              lo_q    <= prod_fix[DATA_W-1:0];
              state_q <= S_DONE;
            end
          end
        end
        S_DIV: begin
          if (annul) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= div_nx;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              hi_q    <= rem_fix;
              lo_q    <= quot_fix;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          dbz_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign stall_req   = ((state_q == S_IDLE) && start && !annul) ||
                       (state_q == S_MUL) || (state_q == S_DIV);
  assign done        = (state_q == S_DONE);
  assign whilo_out   = done;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: vector table plus hand sequences for stall timing,
// annul, re-start, reset mid-op; results checked through a scoreboard queue.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, annul;
  logic [1:0]  op;
  logic [31:0] src1, src2;
  logic        busy, stall_req, done, whilo_out, div_by_zero;
  logic [31:0] hi_out, lo_out;

  muldiv_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
    .annul(annul), .busy(busy), .stall_req(stall_req), .done(done),
    .whilo_out(whilo_out), .hi_out(hi_out), .lo_out(lo_out),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          sc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic [31:0] last_hi = '0, last_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(done), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("hi", 64'(hi_out), 64'(e.hi));
        chk("lo", 64'(lo_out), 64'(e.lo));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        chk("whilo", 64'(whilo_out), 64'(1));
        chk("latency", 64'(cyc - e.sc), 64'(e.lat));
      end
    end
  end

  task automatic drive(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; src1 = a; src2 = b;
  endtask

  task automatic expect_res(input logic [31:0] h, input logic [31:0] l, input logic z,
                            input int lat);
    exp_t e;
    e.hi = h; e.lo = l; e.dbz = z; e.sc = cyc; e.lat = lat;
    q.push_back(e);
    last_hi = h; last_lo = l;
  endtask

  task automatic wait_q();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("done_timeout", 64'(q.size()), 64'(0));
      q.delete();
    end
  endtask

  vec_t vt[13];

  initial begin
    vt[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vt[1]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vt[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vt[3]  = '{2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
    vt[4]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vt[5]  = '{2'b11, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1};
    vt[6]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vt[7]  = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
    vt[8]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vt[9]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
    vt[10] = '{2'b00, 32'h7FFFFFFF, 32'd2,        32'h00000000, 32'hFFFFFFFE, 1'b0};
    vt[11] = '{2'b11, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
    vt[12] = '{2'b10, 32'd0,        32'd0,        32'h00000000, 32'hFFFFFFFF, 1'b1};

    rst = 1'b1; start = 1'b0; annul = 1'b0; op = '0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_stall", 64'(stall_req), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_whilo", 64'(whilo_out), 64'(0));
    chk("rst_dbz", 64'(div_by_zero), 64'(0));
    chk("rst_hilo", {hi_out, lo_out}, 64'(0));

    // MULTU max*max with cycle-by-cycle stall/busy profile
    @(posedge clk); #1;
    drive(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    expect_res(32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
    for (int k = 0; k <= 34; k++) begin
      @(negedge clk);
      chk($sformatf("stall_c%0d", k), 64'(stall_req), 64'(k <= 32));
      chk($sformatf("busy_c%0d", k), 64'(busy), 64'(k >= 1 && k <= 33));
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_q();

    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      drive(vt[i].op, vt[i].a, vt[i].b);
      expect_res(vt[i].hi, vt[i].lo, vt[i].dbz, vt[i].dbz ? 1 : 33);
      @(posedge clk); #1;
      start = 1'b0;
      wait_q();
    end

    // Annul at cycle 10, restart at cycle 12
    @(posedge clk); #1;
    drive(2'b00, 32'd5, 32'd6);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    @(negedge clk);
    chk("annul_busy", 64'(busy), 64'(0));
    chk("annul_hold", {hi_out, lo_out}, {last_hi, last_lo});
    @(posedge clk); #1;
    drive(2'b00, 32'd5, 32'hFFFFFFFA);
    expect_res(32'hFFFFFFFF, 32'hFFFFFFE2, 1'b0, 33);
    @(posedge clk); #1;
    start = 1'b0;
    wait_q();

    // Second start pulse at cycle 5 must be ignored
    @(posedge clk); #1;
    drive(2'b01, 32'd3, 32'd4);
    expect_res(32'h0, 32'h0000000C, 1'b0, 33);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 drive(2'b01, 32'd9, 32'd9);
    @(posedge clk); #1;
    start = 1'b0;
    wait_q();
    repeat (10) @(negedge clk);

    // Reset at cycle 20 of a divide
    @(posedge clk); #1;
    drive(2'b11, 32'd1000, 32'd3);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_flags", {59'b0, busy, stall_req, done, whilo_out, div_by_zero}, 64'(0));
    chk("midrst_hilo", {hi_out, lo_out}, 64'(0));
    last_hi = '0; last_lo = '0;
    repeat (40) @(negedge clk);

    // Start and annul together in IDLE
    @(posedge clk); #1;
    drive(2'b10, 32'd9, 32'd3);
    annul = 1'b1;
    @(negedge clk);
    chk("ann_start_stall", 64'(stall_req), 64'(0));
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    chk("ann_start_busy", 64'(busy), 64'(0));
    repeat (5) @(negedge clk);

    // Annul during DONE still delivers the result
    @(posedge clk); #1;
    drive(2'b11, 32'd9, 32'd0);
    expect_res(32'd9, 32'hFFFFFFFF, 1'b1, 1);
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    wait_q();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multi-cycle multiply/divide sequencer for the HI/LO register path of the execute stage.
- Accepts MULT/MULTU/DIV/DIVU from execute and runs a 1-bit-per-cycle shift-add multiplier or restoring divider.
- Holds the pipeline stalled while an operation is running.
- Delivers a single HI/LO write request when the operation completes.
- Supports annulment by pipeline flush.

Parameters:
DATA_W, 32, operand width; iteration count equals DATA_W.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  execute stage presents a mul/div op this cycle
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
src1  in  DATA_W  rs value (multiplicand / dividend)
src2  in  DATA_W  rt value (multiplier / divisor)
annul  in  1  flush: abandon the current operation
busy  out  1  FSM not in IDLE
stall_req  out  1  stall request to the hazard/stall logic
done  out  1  one-cycle completion pulse
whilo_out  out  1  HI/LO write enable, equals done
hi_out  out  DATA_W  HI result
lo_out  out  DATA_W  LO result
div_by_zero  out  1  completed op was a DIV/DIVU with src2==0; valid with done

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Reset: FSM=IDLE. busy, stall_req, done, whilo_out, div_by_zero = 0. hi_out, lo_out, counter and internal datapath registers = 0.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE, start=1, annul=0:
  - Latch op and the operand magnitudes. For signed ops, take the two's-complement absolute value of each operand. Record sign flags.
  - Load counter = DATA_W.
  - Next state: MUL for op[1]=0; DIV for op[1]=1.
  - Exception: DIV/DIVU with src2==0 goes directly to DONE.
- MUL: each cycle, if the multiplier LSB is set, add the multiplicand into the upper half of the 2*DATA_W accumulator. Shift right 1; counter-1. When counter reaches 1, go to DONE on the next edge. Total 32 cycles in MUL.
- DIV: restoring division. Shift {rem, quot} left 1; trial-subtract the divisor. If no borrow, keep the difference and set the quot LSB. Counter-1. After 32 cycles go to DONE.
- Sign fixup, registered on entry to DONE:
  - Product: negated if signs differ (MULT only).
  - Quotient: negated if signs differ (DIV only).
  - Remainder: takes the dividend sign (DIV only).
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0; no trap.
- Results: MUL gives hi_out=product[63:32], lo_out=product[31:0]. DIV gives hi_out=remainder, lo_out=quotient.
- Divide by zero: hi_out=src1, lo_out=0xFFFFFFFF, div_by_zero=1.
- DONE lasts one cycle: done=whilo_out=1, then back to IDLE. hi_out/lo_out are registered and hold until the next DONE.
- Latency: start at cycle 0 gives done at cycle 33 (normal) or cycle 1 (div by zero). busy is high on cycles 1..33.
- stall_req = (IDLE & start & ~annul) | MUL | DIV. It is combinational, so the stage is frozen from cycle 0. It is low in DONE, so the instruction advances together with the HI/LO write.
- start while not IDLE: ignored. The caller keeps start asserted while stalled; it is not re-accepted after DONE because the instruction advances.
- annul in any state: next state IDLE, no done, hi_out/lo_out unchanged.
- annul and start in the same IDLE cycle: start is ignored.
- annul during DONE: done still pulses this cycle. Flushing that instruction is the pipeline's job.
- rst mid-operation: immediate return to the reset state at the next edge.

Test Plan:
- MULTU 0xFFFFFFFF*0xFFFFFFFF, start at cycle 0 -> done at cycle 33; hi=0xFFFFFFFE, lo=0x00000001; stall_req high on cycles 0..32.
- MULT 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=0x0000000E, hi=0x00000002; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 at cycle 0 -> done and div_by_zero at cycle 1; hi=5, lo=0xFFFFFFFF.
- Start a MULT, assert annul at cycle 10 -> busy=0 at cycle 11, no done, hi/lo keep their previous values. A new start at cycle 12 completes at cycle 45.
- Start pulsed again at cycle 5 during MUL -> ignored, single done at 33. rst at cycle 20 -> all outputs 0 at cycle 21, FSM=IDLE.
